// File: rtl/alu_sched_if.sv
// alu_sched_if: request, response and ALU-drive bundle for the two-port ALU scheduler
interface alu_sched_if #(
    parameter int WIDTH = 16,
    parameter int OP_W = 5
);
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [OP_W-1:0] req0_op, req1_op, alu_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
    logic rsp_valid, rsp_ready, rsp_id, alu_enable;
    modport slave (
        input req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        input rsp_ready, alu_out,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        output alu_enable, alu_op, alu_a, alu_b
    );
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        output rsp_ready, alu_out,
        input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        input alu_enable, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: shares one ALU between two request ports; define ALU_SCHED_RR_EN for round-robin, else port 0 has fixed priority
module alu_sched #(
    parameter int WIDTH = 16,
    parameter int OP_W = 5
) (
    input logic clk,
    input logic reset,
    alu_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic grant, accept, rsp_id_q;
    logic [OP_W-1:0] op_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
`ifdef ALU_SCHED_RR_EN
    logic last;
    assign grant = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
    always_ff @(posedge clk or posedge reset)
        if (reset) last <= 1'b1;
        else if (accept) last <= grant;
`else
    assign grant = bus.req1_valid && !bus.req0_valid;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        accept = 1'b0;
        bus.req0_ready = state == IDLE && !grant && bus.req0_valid;
        bus.req1_ready = state == IDLE && grant && bus.req1_valid;
        accept = bus.req0_ready || bus.req1_ready;
        bus.alu_enable = state == EXEC;
        bus.rsp_valid = state == RESP;
        state_nx = state == IDLE ? (accept ? EXEC : IDLE)
                 : state == EXEC ? RESP
                 : (bus.rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            rsp_id_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (accept) begin
                op_q <= grant ? bus.req1_op : bus.req0_op;
                a_q <= grant ? bus.req1_a : bus.req0_a;
                b_q <= grant ? bus.req1_b : bus.req0_b;
                rsp_id_q <= grant;
            end
            if (state == EXEC) data_q <= bus.alu_out;
        end
    assign bus.alu_op = op_q;
    assign bus.alu_a = a_q;
    assign bus.alu_b = b_q;
    assign bus.rsp_id = rsp_id_q;
    assign bus.rsp_data = data_q;
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler that shares the single combinational ALU datapath between two independent request ports. Each port presents an operation (5-bit op code plus two 16-bit operands) with a valid/ready handshake. The scheduler arbitrates, drives the ALU for exactly one execute cycle, registers the result, and returns it on a single response port tagged with the requester ID. It sits between the instruction-issue logic (port 0) and the auxiliary/address-generation unit (port 1) on one side, and the ALU on the other.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width
- `OP_W`, 5, ALU op-code width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_op`, `req1_op`  in  OP_W  ALU op code; passed through undecoded
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester that issued the result
- `rsp_data`  out  WIDTH  registered ALU result
- `alu_enable`  out  1  drives ALU_enable
- `alu_op`  out  OP_W  drives ALU_op
- `alu_a`, `alu_b`  out  WIDTH  drive ALU operands A, B
- `alu_out`  in  WIDTH  ALU result (combinational)

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: grant is combinational from the valids. `reqN_ready` = IDLE && grant==N. On accept (valid&&ready), latch op/a/b into operand registers, latch grant into `rsp_id`, and go to EXEC.
- EXEC: `alu_enable`=1 for exactly this one cycle. `alu_op`/`alu_a`/`alu_b` come from the latched registers. At the clock edge, capture `alu_out` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1. Data and ID stay stable until `rsp_valid && rsp_ready`, then go to IDLE. No request is accepted in RESP or EXEC.
- `alu_op`, `alu_a` and `alu_b` hold their last latched values outside EXEC. `alu_enable`=0 outside EXEC.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal; nothing is latched in that case.
- Op codes are not checked. Result semantics belong to the ALU: 00001 add, 00010/01000–01010 sub, 00011 inc, 00100 dec, 00101 and, 00110 or, 00111 not A, 00000 xor, other codes pass A. Arithmetic wraps modulo 2^WIDTH.
- Arbitration pointer `last` (1 bit) updates only on accept. With both valids asserted, the grant goes to the requester that is not `last`.

## Timing
- Accept at edge N. EXEC occupies cycle N..N+1. `rsp_valid` rises after edge N+1. Minimum accept-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with `rsp_ready`=1).
- Backpressure: RESP persists indefinitely while `rsp_ready`=0.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `alu_enable`=0, `alu_op`=0, `alu_a`=0, `alu_b`=0, `req*_ready`=0, `last`=1 (port 0 wins the first contention).
- Reset asserted mid-EXEC or mid-RESP: everything returns asynchronously to IDLE and reset values. The in-flight result is discarded with no response.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration via `last`, as described above.
- Not defined: fixed priority, port 0 always wins contention. The `last` register is not built.

## Test plan
- Port 0 ADD, a=0x0005, b=0x0003, `rsp_ready`=1 -> `rsp_valid` 2 cycles after accept, `rsp_data`=0x0008, `rsp_id`=0, `alu_enable` high for exactly 1 cycle.
- Port 1 SUB (01001), a=0x0000, b=0x0001 -> `rsp_data`=0xFFFF, `rsp_id`=1. Port 1 NOT, a=0x00FF -> 0xFF00.
- Both ports valid continuously, RR_EN defined -> grants alternate 0,1,0,1. RR_EN undefined -> all grants to port 0 and port 1 is starved.
- `rsp_ready` held 0 for 5 cycles after a result -> `rsp_valid`/`rsp_data`/`rsp_id` stable, both `req*_ready`=0 throughout. The result drains on the first `rsp_ready`=1 cycle.
- `reset` pulsed during EXEC of INC a=0x7FFF -> no `rsp_valid`, all outputs at reset values. The next port 0 INC a=0xFFFF returns 0x0000.
- `req0_valid` withdrawn in IDLE while port 1 is idle -> no accept, and the ALU is never enabled.
